// File: rtl/axi_arb_pkg.sv
// axi_arb_pkg: shared types and constants for the 2:1 AXI4-Lite arbiter.
package axi_arb_pkg;
    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_XFER, WR_RESP} arb_state_t;
    typedef logic mid_t;
    localparam int NUM_M = 2;
    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
endpackage

// File: rtl/axi_lite_if.sv
// axi_lite_if: 32-bit AXI4-Lite bundle (AR/R/AW/W/B).
interface axi_lite_if;
    logic        arvalid, arready, rvalid, rready, awvalid, awready, wvalid, wready, bvalid, bready;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic [3:0]  wstrb;
    logic [1:0]  rresp, bresp;
    modport master (output arvalid, araddr, rready, awvalid, awaddr, wvalid, wdata, wstrb, bready,
                    input arready, rvalid, rdata, rresp, awready, wready, bvalid, bresp);
    modport slave (input arvalid, araddr, rready, awvalid, awaddr, wvalid, wdata, wstrb, bready,
                   output arready, rvalid, rdata, rresp, awready, wready, bvalid, bresp);
endinterface

// File: rtl/axi_arb_pick.sv
// axi_arb_pick: combinational winner and direction select.
// ARB_ROUND_ROBIN_EN selects alternating tie-break instead of fixed HI_PRIO.
module axi_arb_pick import axi_arb_pkg::*; #(
    parameter bit HI_PRIO  = 1'b1,
    parameter bit WR_FIRST = 1'b1
) (
    input  logic [1:0] req_rd_i,
    input  logic [1:0] req_wr_i,
    input  mid_t       last_i,
    output mid_t       gnt_o,
    output logic       is_wr_o
);
    logic [1:0] req;
    mid_t       tie;
    assign req = req_rd_i | req_wr_i;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit unused_hi_prio = HI_PRIO;
    assign tie = !last_i;
`else
    logic unused_last;
    assign unused_last = last_i;
    assign tie = HI_PRIO;
`endif
    assign gnt_o   = &req ? tie : req[1];
    assign is_wr_o = req_wr_i[gnt_o] && (WR_FIRST || !req_rd_i[gnt_o]);
endmodule

// File: rtl/axi_lite_arbiter.sv
// axi_lite_arbiter: 2:1 AXI4-Lite arbiter, one transaction in flight, grant held until response.
// ARB_ROUND_ROBIN_EN enables round-robin tie-break (builds the last-granted register).
module axi_lite_arbiter import axi_arb_pkg::*; #(
    parameter bit HI_PRIO  = 1'b1,
    parameter bit WR_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    axi_lite_if.slave  m0,
    axi_lite_if.slave  m1,
    axi_lite_if.master s
);
    arb_state_t  state_q;
    mid_t        gnt_q, pick_gnt, last;
    logic        aw_done_q, w_done_q, pick_wr;
    logic        rd_a, rd_d, wr_x, wr_r, aw_act, w_act, aw_fin, w_fin, xfer_done;
    logic [1:0]  arvalid, awvalid, wvalid, rready, bready;
    logic [31:0] araddr [NUM_M];
    logic [31:0] awaddr [NUM_M];
    logic [31:0] wdata [NUM_M];
    logic [3:0]  wstrb [NUM_M];
    assign arvalid = {m1.arvalid, m0.arvalid};
    assign awvalid = {m1.awvalid, m0.awvalid};
    assign wvalid  = {m1.wvalid, m0.wvalid};
    assign rready  = {m1.rready, m0.rready};
    assign bready  = {m1.bready, m0.bready};
    assign araddr  = '{m0.araddr, m1.araddr};
    assign awaddr  = '{m0.awaddr, m1.awaddr};
    assign wdata   = '{m0.wdata, m1.wdata};
    assign wstrb   = '{m0.wstrb, m1.wstrb};
    assign rd_a   = state_q == RD_ADDR;
    assign rd_d   = state_q == RD_DATA;
    assign wr_x   = state_q == WR_XFER;
    assign wr_r   = state_q == WR_RESP;
    assign aw_act = wr_x && !aw_done_q;
    assign w_act  = wr_x && !w_done_q;
    assign s.arvalid = rd_a && arvalid[gnt_q];
    assign s.araddr  = araddr[gnt_q];
    assign s.rready  = rd_d && rready[gnt_q];
    assign s.awvalid = aw_act && awvalid[gnt_q];
    assign s.awaddr  = awaddr[gnt_q];
    assign s.wvalid  = w_act && wvalid[gnt_q];
    assign s.wdata   = wdata[gnt_q];
    assign s.wstrb   = wstrb[gnt_q];
    assign s.bready  = wr_r && bready[gnt_q];
    assign m0.arready = rd_a && !gnt_q && s.arready;
    assign m0.rvalid  = rd_d && !gnt_q && s.rvalid;
    assign m0.awready = aw_act && !gnt_q && s.awready;
    assign m0.wready  = w_act && !gnt_q && s.wready;
    assign m0.bvalid  = wr_r && !gnt_q && s.bvalid;
    assign m0.rdata   = s.rdata;
    assign m0.rresp   = s.rresp;
    assign m0.bresp   = s.bresp;
    assign m1.arready = rd_a && gnt_q && s.arready;
    assign m1.rvalid  = rd_d && gnt_q && s.rvalid;
    assign m1.awready = aw_act && gnt_q && s.awready;
    assign m1.wready  = w_act && gnt_q && s.wready;
    assign m1.bvalid  = wr_r && gnt_q && s.bvalid;
    assign m1.rdata   = s.rdata;
    assign m1.rresp   = s.rresp;
    assign m1.bresp   = s.bresp;
    // a channel counts as finished if it completed earlier or handshakes this cycle
    assign aw_fin    = aw_done_q || (s.awvalid && s.awready);
    assign w_fin     = w_done_q || (s.wvalid && s.wready);
    assign xfer_done = (rd_d && s.rvalid && s.rready) || (wr_r && s.bvalid && s.bready);
`ifdef ARB_ROUND_ROBIN_EN
    mid_t last_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) last_q <= 1'b1;
        else if (xfer_done) last_q <= gnt_q;
    end
    assign last = last_q;
`else
    assign last = 1'b1;
`endif
    axi_arb_pick #(.HI_PRIO(HI_PRIO), .WR_FIRST(WR_FIRST)) u_pick (
        .req_rd_i(arvalid),
        .req_wr_i(awvalid),
        .last_i  (last),
        .gnt_o   (pick_gnt),
        .is_wr_o (pick_wr)
    );
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            gnt_q     <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (|(arvalid | awvalid)) begin
                    gnt_q   <= pick_gnt;
                    state_q <= pick_wr ? WR_XFER : RD_ADDR;
                end
                RD_ADDR: if (s.arvalid && s.arready) state_q <= RD_DATA;
                RD_DATA, WR_RESP: if (xfer_done) state_q <= IDLE;
                WR_XFER: begin
                    aw_done_q <= aw_fin && !w_fin;
                    w_done_q  <= w_fin && !aw_fin;
                    if (aw_fin && w_fin) state_q <= WR_RESP;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
